// File: rtl/rram_pkg.sv
// Shared defaults and the readout state encoding for the RRAM ADC readout sequencer.
package rram_pkg;

  localparam int RRAM_NUM_ADC         = 32;
  localparam int RRAM_ADC_WIDTH_THERM = 15;
  localparam int RRAM_ADC_WIDTH       = 4;
  localparam int RRAM_MUX_DEPTH       = 16;
  localparam int RRAM_DATAOUT_WIDTH   = 64;
  localparam int RRAM_SETTLE_CYCLES   = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    SAMPLE  = 3'd2,
    CAPTURE = 3'd3,
    PUSH_LO = 3'd4,
    PUSH_HI = 3'd5
  } rram_state_e;

endpackage

// File: rtl/rram_adc_readout_sequencer_therm2bin.sv
// Thermometer-to-binary converter: counts set bits so a stray bubble costs at most one LSB.
module rram_therm2bin #(
  parameter int THERM_W = 15,
  parameter int BIN_W   = 4
) (
  input  logic [THERM_W-1:0] therm_i,
  output logic [BIN_W-1:0]   bin_o
);

  logic [BIN_W-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < THERM_W; i++) begin
      cnt = cnt + BIN_W'(therm_i[i]);
    end
    bin_o = cnt;
  end

endmodule

// File: rtl/rram_adc_readout_sequencer.sv
// Steps the SL mux across a column range, samples the shared ADCs per column and
// pushes the packed results to the output FIFO as a low word followed by a high word.
module rram_adc_readout_sequencer
  import rram_pkg::*;
#(
  parameter int NUM_ADC         = RRAM_NUM_ADC,
  parameter int ADC_WIDTH_THERM = RRAM_ADC_WIDTH_THERM,
  parameter int ADC_WIDTH       = RRAM_ADC_WIDTH,
  parameter int MUX_DEPTH       = RRAM_MUX_DEPTH,
  parameter int DATAOUT_WIDTH   = RRAM_DATAOUT_WIDTH,
  parameter int SETTLE_CYCLES   = RRAM_SETTLE_CYCLES
) (
  input  logic                               CLK,
  input  logic                               reset,
  input  logic                               start,
  input  logic [3:0]                         col_first,
  input  logic [3:0]                         col_last,
  output logic                               busy,
  output logic                               done,
  output logic [3:0]                         sl_mux_sel,
  output logic                               adc_sample_en,
  input  logic [NUM_ADC*ADC_WIDTH_THERM-1:0] adc_therm,
  output logic                               push_n_oFIFO,
  input  logic                               full_oFIFO,
  output logic [DATAOUT_WIDTH-1:0]           din_oFIFO
);

  localparam int BIN_W = NUM_ADC * ADC_WIDTH;
  localparam int CAP_W = 2 * DATAOUT_WIDTH;

  rram_state_e        state_q, state_d;
  logic [3:0]         col_q, col_d;
  logic [3:0]         last_q, last_d;
  logic [3:0]         settle_cnt_q, settle_cnt_d;
  logic               done_q, done_d;
  logic [CAP_W-1:0]   cap_q, cap_d;
  logic [BIN_W-1:0]   bin_w;
  logic               push_ok;

  for (genvar g = 0; g < NUM_ADC; g++) begin : g_conv
    rram_therm2bin #(
      .THERM_W (ADC_WIDTH_THERM),
      .BIN_W   (ADC_WIDTH)
    ) u_therm2bin (
      .therm_i (adc_therm[g*ADC_WIDTH_THERM +: ADC_WIDTH_THERM]),
      .bin_o   (bin_w[g*ADC_WIDTH +: ADC_WIDTH])
    );
  end

  // A transfer happens only on an edge where a push state sees room in the FIFO.
  assign push_ok = ((state_q == PUSH_LO) || (state_q == PUSH_HI)) && !full_oFIFO;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      last_q       <= '0;
      settle_cnt_q <= '0;
      done_q       <= 1'b0;
      cap_q        <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      last_q       <= last_d;
      settle_cnt_q <= settle_cnt_d;
      done_q       <= done_d;
      cap_q        <= cap_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    last_d       = last_q;
    settle_cnt_d = settle_cnt_q;
    done_d       = 1'b0;
    cap_d        = cap_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          col_d        = col_first;
          last_d       = col_last;
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == 4'(SETTLE_CYCLES - 1)) begin
          state_d = SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      SAMPLE: state_d = CAPTURE;
      CAPTURE: begin
        cap_d   = CAP_W'(bin_w);
        state_d = PUSH_LO;
      end
      PUSH_LO: begin
        if (push_ok) state_d = PUSH_HI;
      end
      PUSH_HI: begin
        if (push_ok) begin
          if (col_q == last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            col_d        = (col_q == 4'(MUX_DEPTH - 1)) ? 4'd0 : col_q + 4'd1;
            settle_cnt_d = '0;
            state_d      = SETTLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign sl_mux_sel    = col_q;
  assign adc_sample_en = (state_q == SAMPLE);
  assign push_n_oFIFO  = !push_ok;

  always_comb begin
    din_oFIFO = '0;
    if (state_q == PUSH_LO) din_oFIFO = cap_q[DATAOUT_WIDTH-1:0];
    else if (state_q == PUSH_HI) din_oFIFO = cap_q[CAP_W-1:DATAOUT_WIDTH];
  end

endmodule
